// File: rtl/qcore_mem_dma_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | qcore_mem_dma_ctrl : AXI-Stream burst sequencer for the core memory PS port |
// | Optional: QMEM_DMA_TLAST_CHECK_EN adds write tlast/length checking (err_o). |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module qcore_mem_dma_ctrl #(
  parameter int DW = 168,
  parameter int AW = 16
) (
  input  logic          ps_clk_i,
  input  logic          ps_rst_ni,
  input  logic          start_i,
  input  logic          dir_i,
  input  logic [1:0]    sel_i,
  input  logic [AW-1:0] addr_i,
  input  logic [AW-1:0] len_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          err_o,
  input  logic [DW-1:0] s_axis_tdata_i,
  input  logic          s_axis_tvalid_i,
  input  logic          s_axis_tlast_i,
  output logic          s_axis_tready_o,
  output logic [DW-1:0] m_axis_tdata_o,
  output logic          m_axis_tvalid_o,
  output logic          m_axis_tlast_o,
  input  logic          m_axis_tready_i,
  output logic [1:0]    mem_sel_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_w_dt_o,
  input  logic [DW-1:0] mem_r_dt_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2,
    FIN  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [1:0]           sel_q, sel_d;
  logic [AW-1:0]        addr_q, addr_d;     // next write address / next read-issue address
  logic [AW-1:0]        rem_q, rem_d;       // beats left to accept (WR) or to issue (RD)
  logic [AW-1:0]        orem_q, orem_d;     // beats left to deliver on m_axis
  logic                 mem_we_q, mem_we_d;
  logic [AW-1:0]        mem_addr_q, mem_addr_d;
  logic [DW-1:0]        mem_w_dt_q, mem_w_dt_d;
  logic                 done_q, done_d;
  logic                 infl_q, infl_d;
  logic [1:0][DW-1:0]   fifo_q, fifo_d;
  logic                 wp_q, wp_d;
  logic                 rp_q, rp_d;
  logic [1:0]           cnt_q, cnt_d;

  logic                 s_hs;
  logic                 m_pop;
  logic                 rd_issue;
  logic [2:0]           occ;

`ifdef QMEM_DMA_TLAST_CHECK_EN
  logic                 err_q, err_d;
`else
  logic                 unused_tlast;
  assign unused_tlast = s_axis_tlast_i;
`endif

  always_ff @(posedge ps_clk_i) begin
    if (!ps_rst_ni) begin
      state_q    <= IDLE;
      sel_q      <= 2'b00;
      addr_q     <= '0;
      rem_q      <= '0;
      orem_q     <= '0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_w_dt_q <= '0;
      done_q     <= 1'b0;
      infl_q     <= 1'b0;
      fifo_q     <= '0;
      wp_q       <= 1'b0;
      rp_q       <= 1'b0;
      cnt_q      <= 2'd0;
`ifdef QMEM_DMA_TLAST_CHECK_EN
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      orem_q     <= orem_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_w_dt_q <= mem_w_dt_d;
      done_q     <= done_d;
      infl_q     <= infl_d;
      fifo_q     <= fifo_d;
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      cnt_q      <= cnt_d;
`ifdef QMEM_DMA_TLAST_CHECK_EN
      err_q      <= err_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    orem_d     = orem_q;
    mem_we_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_w_dt_d = mem_w_dt_q;
    done_d     = (state_q == FIN);
    infl_d     = 1'b0;
    fifo_d     = fifo_q;
    wp_d       = wp_q;
    rp_d       = rp_q;
    cnt_d      = cnt_q;
`ifdef QMEM_DMA_TLAST_CHECK_EN
    err_d      = err_q;
`endif

    s_hs  = (state_q == WR) && s_axis_tvalid_i;
    m_pop = (state_q == RD) && (cnt_q != 2'd0) && m_axis_tready_i;
    // Count the beat leaving this cycle as already gone so a full-rate stream keeps one read in flight.
    occ      = {1'b0, cnt_q} + {2'b00, infl_q} - {2'b00, m_pop};
    rd_issue = (state_q == RD) && (rem_q != '0) && (occ < 3'd2);

    case (state_q)
      IDLE: begin
        if (start_i) begin
`ifdef QMEM_DMA_TLAST_CHECK_EN
          err_d = 1'b0;
`endif
          if ((len_i == '0) || (sel_i == 2'b00)) begin
            state_d = FIN;
          end else begin
            sel_d   = sel_i;
            addr_d  = addr_i;
            rem_d   = len_i;
            orem_d  = len_i;
            state_d = dir_i ? RD : WR;
          end
        end
      end

      WR: begin
        if (s_hs) begin
          mem_we_d   = 1'b1;
          mem_addr_d = addr_q;
          mem_w_dt_d = s_axis_tdata_i;
          addr_d     = addr_q + AW'(1);
          rem_d      = rem_q - AW'(1);
          if (rem_q == AW'(1)) begin
            state_d = FIN;
          end
`ifdef QMEM_DMA_TLAST_CHECK_EN
          if (s_axis_tlast_i != (rem_q == AW'(1))) begin
            err_d = 1'b1;
          end
          if (s_axis_tlast_i) begin
            state_d = FIN;
          end
`endif
        end
      end

      RD: begin
        if (rd_issue) begin
          addr_d = addr_q + AW'(1);
          rem_d  = rem_q - AW'(1);
          infl_d = 1'b1;
        end
        if (infl_q) begin
          fifo_d[wp_q] = mem_r_dt_i;
          wp_d         = ~wp_q;
        end
        if (m_pop) begin
          rp_d   = ~rp_q;
          orem_d = orem_q - AW'(1);
          if (orem_q == AW'(1)) begin
            state_d = FIN;
          end
        end
        cnt_d = cnt_q + {1'b0, infl_q} - {1'b0, m_pop};
      end

      FIN: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy_o          = (state_q == WR) || (state_q == RD);
  assign done_o          = done_q;
`ifdef QMEM_DMA_TLAST_CHECK_EN
  assign err_o           = err_q;
`else
  assign err_o           = 1'b0;
`endif
  assign s_axis_tready_o = (state_q == WR);
  assign m_axis_tvalid_o = (cnt_q != 2'd0);
  assign m_axis_tdata_o  = m_axis_tvalid_o ? fifo_q[rp_q] : '0;
  assign m_axis_tlast_o  = m_axis_tvalid_o && (orem_q == AW'(1));
  // The final write is presented in FIN, so the select follows the registered write as well.
  assign mem_sel_o       = (busy_o || mem_we_q) ? sel_q : 2'b00;
  assign mem_we_o        = mem_we_q;
  assign mem_addr_o      = (state_q == RD) ? addr_q : mem_addr_q;
  assign mem_w_dt_o      = mem_w_dt_q;

endmodule
`default_nettype wire

// File: tb/tb_qcore_mem_dma_ctrl.sv
`default_nettype none
// tb_qcore_mem_dma_ctrl : scoreboard bench with a sparse memory model and a queue-based reference.
// Honours QMEM_DMA_TLAST_CHECK_EN when the design is built with it.
module tb_qcore_mem_dma_ctrl;
  localparam int DW = 168;
  localparam int AW = 16;
  typedef logic [DW-1:0] word_t;
  typedef logic [17:0]   key_t;
  typedef struct packed { logic [1:0] sel; logic [AW-1:0] addr; word_t d; } wr_t;
  typedef struct packed { word_t d; logic last; } rd_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_i = 1'b0;
  logic          dir_i = 1'b0;
  logic [1:0]    sel_i = 2'b00;
  logic [AW-1:0] addr_i = '0;
  logic [AW-1:0] len_i = '0;
  logic          busy_o, done_o, err_o;
  word_t         s_tdata = '0;
  logic          s_tvalid = 1'b0;
  logic          s_tlast = 1'b0;
  logic          s_tready;
  word_t         m_tdata;
  logic          m_tvalid, m_tlast;
  logic          m_tready = 1'b0;
  logic [1:0]    mem_sel;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  word_t         mem_w_dt;
  word_t         mem_r_dt = '0;

  always #5 clk = ~clk;

  qcore_mem_dma_ctrl #(.DW(DW), .AW(AW)) dut (
    .ps_clk_i(clk), .ps_rst_ni(rst_n),
    .start_i(start_i), .dir_i(dir_i), .sel_i(sel_i), .addr_i(addr_i), .len_i(len_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .s_axis_tdata_i(s_tdata), .s_axis_tvalid_i(s_tvalid), .s_axis_tlast_i(s_tlast),
    .s_axis_tready_o(s_tready),
    .m_axis_tdata_o(m_tdata), .m_axis_tvalid_o(m_tvalid), .m_axis_tlast_o(m_tlast),
    .m_axis_tready_i(m_tready),
    .mem_sel_o(mem_sel), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_w_dt_o(mem_w_dt), .mem_r_dt_i(mem_r_dt)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic flag(input string name, input logic [191:0] act);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got %h expected nothing", name, act);
  endtask

  // Memory contents before any write, shared by the device model and the reference.
  function automatic word_t init_val(input key_t k);
    return {k, 6'h15, {4{32'hC0DE_0000 ^ {14'h0, k}}}, 16'hBEEF};
  endfunction

  word_t dev_mem [key_t];
  word_t ref_mem [key_t];

  function automatic word_t ref_rd(input key_t k);
    if (ref_mem.exists(k)) return ref_mem[k];
    return init_val(k);
  endfunction

  function automatic word_t rand_word();
    logic [191:0] r;
    r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return r[DW-1:0];
  endfunction

  // Device memory: port sampled mid-cycle, read data returned one cycle after the address.
  key_t  lat_k;
  logic  lat_we;
  word_t lat_wd;
  always @(negedge clk) begin
    lat_k  = {mem_sel, mem_addr};
    lat_we = mem_we && (mem_sel != 2'b00);
    lat_wd = mem_w_dt;
  end
  always @(posedge clk) begin
    mem_r_dt <= dev_mem.exists(lat_k) ? dev_mem[lat_k] : init_val(lat_k);
    if (lat_we) dev_mem[lat_k] = lat_wd;
  end

  int   tr_mode = 0;
  int   tr_idx = 0;
  logic [3:0] tr_pat = 4'b1001;
  always @(posedge clk) begin
    #1;
    case (tr_mode)
      0:       m_tready = 1'b1;
      1:       begin m_tready = tr_pat[tr_idx % 4]; tr_idx++; end
      default: m_tready = 1'($urandom_range(0, 1));
    endcase
  end

  wr_t  exp_wr_q[$];
  rd_t  exp_rd_q[$];
  int   exp_done_q[$];
  int   dones_expected = 0;
  logic exp_err = 1'b0;

  int   done_seen = 0;
  int   beats_seen = 0;
  int   last_we_cyc = 0;
  int   done_cyc = 0;
  int   first_beat_cyc = 0;
  int   last_beat_cyc = 0;
  logic first_pending = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_we) begin
        last_we_cyc = cyc;
        if (exp_wr_q.size() == 0) begin
          flag("unexpected_mem_write", {mem_sel, mem_addr});
        end else begin
          wr_t e;
          e = exp_wr_q.pop_front();
          chk("wr_sel_addr", {mem_sel, mem_addr}, {e.sel, e.addr});
          chk("wr_data", mem_w_dt, e.d);
        end
      end
      if (m_tvalid && m_tready) begin
        beats_seen++;
        last_beat_cyc = cyc;
        if (first_pending) begin first_beat_cyc = cyc; first_pending = 1'b0; end
        if (exp_rd_q.size() == 0) begin
          flag("unexpected_rd_beat", m_tdata);
        end else begin
          rd_t r;
          r = exp_rd_q.pop_front();
          chk("rd_data", m_tdata, r.d);
          chk("rd_last", m_tlast, r.last);
        end
      end
      if (done_o) begin
        done_seen++;
        done_cyc = cyc;
        if (exp_done_q.size() == 0) begin
          flag("unexpected_done", done_o);
        end else begin
          void'(exp_done_q.pop_front());
          chk("busy_at_done", busy_o, 1'b0);
          chk("err_at_done", err_o, exp_err);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic dir, input logic [1:0] sel, input logic [AW-1:0] addr,
                             input logic [AW-1:0] len);
    start_i = 1'b1; dir_i = dir; sel_i = sel; addr_i = addr; len_i = len;
    tick();
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done_seen < dones_expected && n < budget) begin tick(); n++; end
    if (done_seen < dones_expected) begin
      flag("done_timeout", done_seen);
      done_seen = dones_expected;
    end
    tick();
  endtask

  task automatic push_done();
    exp_done_q.push_back(dones_expected);
    dones_expected++;
  endtask

  task automatic run_null(input logic dir, input logic [1:0] sel, input logic [AW-1:0] len);
    exp_err = 1'b0;
    push_done();
    pulse_start(dir, sel, 16'h0033, len);
`ifdef QMEM_DMA_TLAST_CHECK_EN
    chk("err_cleared_by_start", err_o, 1'b0);
`endif
    chk("null_c1_busy_done_rdy_sel", {busy_o, done_o, s_tready, mem_sel}, 5'b0);
    tick();
    chk("null_c2_done", done_o, 1'b1);
    chk("null_c2_sel", mem_sel, 2'b00);
    wait_done(10);
  endtask

  task automatic run_write(input logic [1:0] sel, input logic [AW-1:0] addr, input int len,
                           input bit inject, input bit seq, input int early);
    word_t data[$];
    int n_wr, beat, n;
    bit injected;
    logic rdy;
    n_wr = (early >= 0) ? early + 1 : len;
    exp_err = (early >= 0);
    for (int i = 0; i < len; i++) data.push_back(seq ? word_t'(i + 1) : rand_word());
    for (int i = 0; i < n_wr; i++) begin
      exp_wr_q.push_back({sel, AW'(addr + i), data[i]});
      ref_mem[{sel, AW'(addr + i)}] = data[i];
    end
    push_done();
    pulse_start(1'b0, sel, addr, AW'(len));
    beat = 0; n = 0; injected = 0;
    while (beat < n_wr && n < 30 * len + 50) begin
      s_tvalid = seq ? 1'b1 : ($urandom_range(0, 3) != 0);
      s_tdata  = data[beat];
      s_tlast  = (beat == len - 1) || (beat == early);
`ifndef QMEM_DMA_TLAST_CHECK_EN
      if (!s_tlast) s_tlast = 1'($urandom_range(0, 1));
`endif
      if (inject && beat == 1 && !injected) begin
        start_i = 1'b1; dir_i = 1'b1; sel_i = 2'b10; addr_i = 16'h1234; len_i = 16'd5;
        injected = 1;
      end
      rdy = s_tready;
      tick();
      start_i = 1'b0;
      if (s_tvalid && rdy) beat++;
      n++;
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    if (beat < n_wr) flag("wr_beat_timeout", beat);
    wait_done(30);
    chk("wr_done_after_last_we", done_cyc - last_we_cyc, 1);
  endtask

  task automatic run_read(input logic [1:0] sel, input logic [AW-1:0] addr, input int len,
                          input int mode);
    exp_err = 1'b0;
    tr_mode = mode;
    tr_idx  = 0;
    for (int i = 0; i < len; i++)
      exp_rd_q.push_back({ref_rd({sel, AW'(addr + i)}), (i == len - 1)});
    push_done();
    first_pending = 1'b1;
    pulse_start(1'b1, sel, addr, AW'(len));
    wait_done(30 * len + 50);
    if (mode == 0 && len >= 2) chk("rd_full_rate", last_beat_cyc - first_beat_cyc, len - 1);
  endtask

  initial begin
    int n, b0;
    repeat (3) tick();
    chk("reset_outputs", {busy_o, done_o, err_o, s_tready, m_tvalid, m_tlast, mem_sel, mem_we, mem_addr}, 0);
    chk("reset_data_outputs", {m_tdata, mem_w_dt}, 0);
    rst_n = 1'b1;
    tick();

    run_write(2'b01, 16'h0010, 4, 0, 1, -1);
    // Same words through the wave memory path, so the read returns 1..4 from there.
    run_write(2'b11, 16'h0010, 4, 0, 1, -1);
    run_read(2'b11, 16'h0010, 4, 1);
    run_write(2'b10, 16'hFFFE, 3, 0, 0, -1);
    run_read(2'b10, 16'hFFFE, 3, 0);
    run_null(1'b0, 2'b01, 16'd0);
    run_null(1'b1, 2'b00, 16'd6);
    run_write(2'b01, 16'h0020, 6, 1, 0, -1);
    run_read(2'b01, 16'h0020, 6, 2);

    // Abort a read burst of 8 while its second beat is on the stream.
    tr_mode = 0;
    for (int i = 0; i < 8; i++)
      exp_rd_q.push_back({ref_rd({2'b10, AW'(16'h0100 + i)}), (i == 7)});
    b0 = beats_seen;
    pulse_start(1'b1, 2'b10, 16'h0100, 16'd8);
    n = 0;
    while (beats_seen < b0 + 1 && n < 50) begin tick(); n++; end
    if (beats_seen < b0 + 1) flag("abort_first_beat_timeout", beats_seen);
    rst_n = 1'b0;
    tick();
    chk("abort_outputs", {busy_o, done_o, err_o, s_tready, m_tvalid, m_tlast, mem_sel, mem_we, mem_addr}, 0);
    chk("abort_data_outputs", {m_tdata, mem_w_dt}, 0);
    rst_n = 1'b1;
    exp_rd_q.delete();
    repeat (6) tick();
    run_read(2'b10, 16'h0100, 8, 0);

`ifdef QMEM_DMA_TLAST_CHECK_EN
    run_write(2'b10, 16'h0040, 4, 0, 0, 1);
    chk("err_after_early_tlast", err_o, 1'b1);
    run_null(1'b0, 2'b01, 16'd0);
    run_read(2'b10, 16'h0040, 4, 0);
`endif

    for (int k = 0; k < 30; k++) begin
      logic [1:0]    s;
      logic [AW-1:0] a;
      int            l;
      s = ($urandom_range(0, 9) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
      a = ($urandom_range(0, 3) == 0) ? AW'(16'hFFF8 + $urandom_range(0, 7)) : AW'($urandom_range(0, 63));
      l = $urandom_range(0, 10);
      if (s == 2'b00 || l == 0) run_null(1'($urandom_range(0, 1)), s, AW'(l));
      else if ($urandom_range(0, 1) == 0) run_write(s, a, l, 0, 0, -1);
      else run_read(s, a, l, $urandom_range(0, 2));
    end

    repeat (5) tick();
    chk("wr_queue_drained", exp_wr_q.size(), 0);
    chk("rd_queue_drained", exp_rd_q.size(), 0);
    chk("done_queue_drained", exp_done_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
